// File: rtl/ysyx_220053_if_id_queue.sv
// IFU -> IDU instruction fetch queue: circular buffer with valid/ready on both sides and a flush.
// Define YSYX_220053_IFQ_BYPASS_EN to add a zero-latency pass-through while the queue is empty.
module ysyx_220053_if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_pc_q    [DEPTH];
    logic [63:0]   mem_pc_d    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];
    logic [63:0]   last_pc_q, last_pc_d;
    logic [31:0]   last_instr_q, last_instr_d;

    logic full, empty;
    logic head_valid;
    logic enq, deq;
    logic [63:0] head_pc;
    logic [31:0] head_instr;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign head_valid = !empty && !flush;
    assign deq        = head_valid && out_ready;
    assign count      = count_q;

    // Once drained, keep presenting the entry most recently handed to decode.
    assign head_pc    = empty ? last_pc_q    : mem_pc_q[rptr_q];
    assign head_instr = empty ? last_instr_q : mem_instr_q[rptr_q];

`ifdef YSYX_220053_IFQ_BYPASS_EN
    logic bypass;
    assign bypass    = empty && in_valid && !flush;
    // A bypassed entry taken by decode in the same cycle never touches storage.
    assign enq       = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign out_valid = head_valid || bypass;
    assign out_pc    = bypass ? in_pc    : head_pc;
    assign out_instr = bypass ? in_instr : head_instr;
`else
    assign enq       = in_valid && in_ready && !flush;
    assign out_valid = head_valid;
    assign out_pc    = head_pc;
    assign out_instr = head_instr;
`endif

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        mem_pc_d     = mem_pc_q;
        mem_instr_d  = mem_instr_q;
        last_pc_d    = last_pc_q;
        last_instr_d = last_instr_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                mem_pc_d[wptr_q]    = in_pc;
                mem_instr_d[wptr_q] = in_instr;
                wptr_d              = wptr_q + PW'(1);
            end
            if (deq) begin
                last_pc_d    = mem_pc_q[rptr_q];
                last_instr_d = mem_instr_q[rptr_q];
                rptr_d       = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            last_pc_q    <= last_pc_d;
            last_instr_q <= last_instr_d;
            mem_pc_q     <= mem_pc_d;
            mem_instr_q  <= mem_instr_d;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_if_id_queue.sv
// Directed bench for ysyx_220053_if_id_queue; honours YSYX_220053_IFQ_BYPASS_EN for bypass expectations.
module tb_ysyx_220053_if_id_queue;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    int checks = 0;
    int passed = 0;

    ysyx_220053_if_id_queue #(
        .DEPTH(4),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        in_valid = 1'b0;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if (out_pc !== 64'h0) $display("FAIL reset_out_pc got %h want 0", out_pc); else passed++;
        checks++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr got %h want 0", out_instr); else passed++;
        step();
        rst = 1'b1;
        step();
        in_valid = 1'b1; in_pc = 64'h8000_0000; in_instr = 32'h0000_0413; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_pc !== 64'h8000_0000) $display("FAIL basic_out_pc got %h want 80000000", out_pc); else passed++;
        checks++; if (out_instr !== 32'h0000_0413) $display("FAIL basic_out_instr got %h want 00000413", out_instr); else passed++;
        checks++; if (count !== 3'd1) $display("FAIL basic_count got %0d want 1", count); else passed++;
        do_flush();
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_pc = 64'h8000_0000 + 64'(4 * k); in_instr = 32'(k + 1);
            step();
        end
        #1;
        checks++; if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else passed++;
        in_pc = 64'h8000_0010; in_instr = 32'hdead_beef;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd4) $display("FAIL full_fifth_ignored got %0d want 4", count); else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid_%0d got %b want 1", k, out_valid); else passed++;
            checks++; if (out_pc !== 64'h8000_0000 + 64'(4 * k))
                $display("FAIL drain_pc_%0d got %h want %h", k, out_pc, 64'h8000_0000 + 64'(4 * k)); else passed++;
            checks++; if (out_instr !== 32'(k + 1))
                $display("FAIL drain_instr_%0d got %h want %h", k, out_instr, 32'(k + 1)); else passed++;
            if (k == 0) begin
                checks++; if (in_ready !== 1'b0) $display("FAIL drain_in_ready_same got %b want 0", in_ready); else passed++;
            end
            if (k == 1) begin
                checks++; if (in_ready !== 1'b1) $display("FAIL drain_in_ready_next got %b want 1", in_ready); else passed++;
            end
            step();
        end
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL drained_out_valid got %b want 0", out_valid); else passed++;
        step();
        #1;
        checks++; if (count !== 3'd0) $display("FAIL empty_read_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL empty_read_valid got %b want 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int idx = 0;
        int gaps = 0;
        int max_count = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 10);
            in_pc = 64'h8000_0000 + 64'(4 * c);
            in_instr = 32'h1000 + 32'(c);
            #1;
            if (int'(count) > max_count) max_count = int'(count);
            if (out_valid && out_ready) begin
                if (idx < 10) begin
                    checks++; if (out_pc !== 64'h8000_0000 + 64'(4 * idx))
                        $display("FAIL wrap_pc_%0d got %h want %h", idx, out_pc, 64'h8000_0000 + 64'(4 * idx));
                    else passed++;
                end
                idx++;
            end else if (idx > 0 && idx < 10) begin
                gaps++;
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (idx !== 10) $display("FAIL wrap_total got %0d want 10", idx); else passed++;
        checks++; if (gaps !== 0) $display("FAIL wrap_gaps got %0d want 0", gaps); else passed++;
        checks++; if (max_count > 1) $display("FAIL wrap_max_count got %0d want <=1", max_count); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_pc = 64'h8000_0100 + 64'(4 * k); in_instr = 32'(k);
            step();
        end
        #1;
        checks++; if (count !== 3'd3) $display("FAIL flush_pre_count got %0d want 3", count); else passed++;
        flush = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_1000; in_instr = 32'hbad0_0000;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_cycle_valid got %b want 0", out_valid); else passed++;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else passed++;
        in_valid = 1'b1; in_pc = 64'h8000_2000; in_instr = 32'h0000_0013;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (out_pc !== 64'h8000_2000) $display("FAIL flush_next_pc got %h want 80002000", out_pc); else passed++;
        checks++; if (count !== 3'd1) $display("FAIL flush_next_count got %0d want 1", count); else passed++;
        do_flush();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_pc = 64'h8000_0200 + 64'(4 * k); in_instr = 32'h77;
            step();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd2) $display("FAIL areset_pre_count got %0d want 2", count); else passed++;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (count !== 3'd0) $display("FAIL areset_count got %0d want 0", count); else passed++;
        checks++; if (out_pc !== 64'h0) $display("FAIL areset_out_pc got %h want 0", out_pc); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got %b want 1", in_ready); else passed++;
        #1 rst = 1'b1;
        in_valid = 1'b1; in_pc = 64'h8000_0300; in_instr = 32'h99;
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd1) $display("FAIL areset_first_enq got %0d want 1", count); else passed++;
        checks++; if (out_pc !== 64'h8000_0300) $display("FAIL areset_first_pc got %h want 80000300", out_pc); else passed++;
        do_flush();
    endtask

    task automatic test_bypass();
        out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0020; in_instr = 32'h0000_0093;
        #1;
`ifdef YSYX_220053_IFQ_BYPASS_EN
        checks++; if (out_valid !== 1'b1) $display("FAIL bypass_valid got %b want 1", out_valid); else passed++;
        checks++; if (out_pc !== 64'h8000_0020) $display("FAIL bypass_pc got %h want 80000020", out_pc); else passed++;
`else
        checks++; if (out_valid !== 1'b0) $display("FAIL bypass_valid got %b want 0", out_valid); else passed++;
`endif
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
`ifdef YSYX_220053_IFQ_BYPASS_EN
        checks++; if (count !== 3'd0) $display("FAIL bypass_count got %0d want 0", count); else passed++;
`else
        checks++; if (count !== 3'd1) $display("FAIL bypass_count got %0d want 1", count); else passed++;
        checks++; if (out_pc !== 64'h8000_0020) $display("FAIL bypass_late_pc got %h want 80000020", out_pc); else passed++;
`endif
        do_flush();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_220053_if_id_queue.md
# ysyx_220053_if_id_queue

Instruction fetch queue between the IFU and the IDU: accepts one fetched {pc, instr} pair per cycle from the IFU and presents it to the decode stage over a valid/ready handshake. Decouples IFU fetch from IDU stalls. Supports a single-cycle flush for redirects (branch/jump/exception) that discards all buffered instructions.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  discard all entries; also blocks this cycle's enqueue.
- in_valid  in  1  IFU presents a fetched instruction.
- in_ready  out  1  queue can accept; equals !full.
- in_pc  in  64  PC of the fetched instruction.
- in_instr  in  32  fetched instruction word.
- out_valid  out  1  entry available for IDU.
- out_ready  in  1  IDU consumes the head entry this cycle.
- out_pc  out  64  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries {pc[63:0], instr[31:0]}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue: fires when in_valid && in_ready && !flush. Writes at wptr. Increments wptr.
- Dequeue: fires when out_valid && out_ready && !flush. Increments rptr.
- count: next = count + enq − deq. A simultaneous enqueue and dequeue leaves count unchanged.
- full is (count == DEPTH); empty is (count == 0).
- in_ready = !full. in_ready depends only on registered state, never on out_ready. A full queue with a dequeue in the same cycle still refuses input.
- out_valid = !empty && !flush. out_pc and out_instr come from the entry at rptr.
  - When empty, out_pc and out_instr hold the last-read entry contents. They are don't-care to the consumer.
- Flush: has priority over everything else. On the next edge, wptr = rptr = 0 and count = 0. Any in_valid in the flush cycle is dropped. No dequeue is reported in the flush cycle.
- Input data is captured only on an enqueue. in_pc/in_instr are ignored otherwise.
- Reset value of every state element is 0: pointers, count, and storage.

## Timing
- Reset asserted (rst=0), at any time including mid-operation: immediately clears pointers and count.
  - Outputs then read out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
  - After release, the first enqueue is accepted on the first rising edge.
- Latency without bypass: an entry enqueued at edge N has out_valid=1 in cycle N+1.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Full: in_ready=0 until a dequeue edge lowers count. in_ready rises in the following cycle.
- Empty with out_ready=1: nothing happens. out_valid stays 0.
- Simultaneous enqueue and dequeue at count=1: the head advances to the new entry, and count stays 1.

## Configuration
- YSYX_220053_IFQ_BYPASS_EN defined: zero-latency pass-through when the queue is empty.
  - Condition: empty && in_valid && !flush.
  - In that cycle out_valid=1, out_pc=in_pc, out_instr=in_instr, combinationally.
  - If out_ready=1 in that cycle, the entry is consumed directly: no write, count stays 0.
  - If out_ready=0, the entry is enqueued normally and becomes the head.
- YSYX_220053_IFQ_BYPASS_EN undefined: no combinational in→out path. Minimum latency is 1 cycle as above.

## Test plan
- Reset/basic: rst low then high; enqueue pc=0x80000000, instr=0x00000413 with out_ready=0.
  - Next cycle out_valid=1, out_pc=0x80000000, out_instr=0x00000413, count=1.
- Fill/full: out_ready=0; enqueue 4 entries pc=0x80000000..0x8000000C.
  - count=4, in_ready=0. A 5th in_valid is ignored.
  - Then out_ready=1: entries drain in order, in_ready=1 one cycle after the first dequeue.
- Wrap-around: stream 10 entries with in_valid=1 and out_ready=1 continuously.
  - Output pc sequence is exactly 0x80000000+4k, k=0..9, with no gaps after the first entry. count never exceeds 1.
- Flush: with 3 entries queued, assert flush together with in_valid (pc=0x80001000).
  - Next cycle count=0, out_valid=0. pc 0x80001000 never appears at the output.
- Async reset mid-stream: drop rst while count=2, between clock edges.
  - out_valid=0 and count=0 immediately, without a clock edge.
- Bypass (macro defined): empty queue, in_valid=1, out_ready=1, pc=0x80000020.
  - Same cycle out_valid=1, out_pc=0x80000020. count remains 0.
  - With the macro undefined, out_valid=0 in that cycle.
